// File: rtl/bulk_out_pkt_buf.sv
// bulk_out_pkt_buf: USB bulk OUT packet buffer. Bytes are staged behind
// wr_cmt and become visible on the AXI-Stream side only once a packet
// commits; bad or dropped packets are rewound.
// Ports: clock/reset_n (sync, active low); rx_* receive side from the
// packet decoder; hs_ack_o/hs_nak_o one-cycle handshake requests;
// m_t* AXI-Stream out (tlast = last byte of a USB packet); level_o =
// committed bytes not yet accepted downstream.
// Build option: BULK_OUT_DATA_TOGGLE_EN adds DATA0/DATA1 duplicate filtering.
module bulk_out_pkt_buf #(
  parameter int ABITS   = 11,
  parameter int MAX_PKT = 512
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           rx_start_i,
  input  logic           rx_data1_i,
  input  logic           rx_tvalid_i,
  input  logic [7:0]     rx_tdata_i,
  input  logic           rx_end_i,
  input  logic           rx_crc_ok_i,
  output logic           hs_ack_o,
  output logic           hs_nak_o,
  output logic           m_tvalid_o,
  input  logic           m_tready_i,
  output logic           m_tlast_o,
  output logic [7:0]     m_tdata_o,
  output logic [ABITS:0] level_o
);

  localparam int DEPTH = 1 << ABITS;
  localparam int CW    = $clog2(MAX_PKT + 2);
  localparam logic [ABITS:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, RECV, DROP, RESP} state_t;

  state_t state_q, state_d;

  logic [8:0] mem [DEPTH];

  logic [ABITS:0] wr_tmp, wr_cmt, rd_ptr, rd_fetch;
  logic [ABITS:0] cmt_eff, used;
  logic [ABITS+1:0] free_b;
  logic space_ok;

  logic          commit_q;
  logic          nak_q, nak_d;
  logic          pend_vld_q;
  logic [7:0]    pend_q;
  logic [CW-1:0] cnt_q;

  logic start, rewind, take, flip;
  logic wr_en, wr_last, set_commit;
  logic hs_ack_d, hs_nak_d;
  logic dup;

  logic       rd_req, rvalid_q, pop;
  logic [8:0] rdata_q;
  logic [8:0] sk_d [2];
  logic       sk_rp, sk_wp;
  logic [1:0] sk_cnt;

  // A commit scheduled last cycle lands this cycle; count it as
  // committed so a back-to-back start sees the true occupancy.
  assign cmt_eff  = commit_q ? wr_tmp : wr_cmt;
  assign used     = cmt_eff - rd_ptr;
  assign free_b   = (ABITS+2)'(DEPTH) - {1'b0, used};
  assign space_ok = free_b >= (ABITS+2)'(MAX_PKT);

`ifdef BULK_OUT_DATA_TOGGLE_EN
  logic tog_q, pid_q;
  assign dup = pid_q != tog_q;
`else
  logic unused_tog;
  assign unused_tog = rx_data1_i ^ flip;
  assign dup = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    nak_d      = nak_q;
    start      = 1'b0;
    rewind     = 1'b0;
    take       = 1'b0;
    flip       = 1'b0;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    set_commit = 1'b0;
    hs_ack_d   = (state_q == RESP) && !nak_q;
    hs_nak_d   = (state_q == RESP) && nak_q;
    if (rx_start_i) begin
      start   = 1'b1;
      rewind  = 1'b1;
      nak_d   = !space_ok;
      state_d = space_ok ? RECV : DROP;
    end else begin
      unique case (state_q)
        IDLE: ;
        RECV: begin
          if (rx_end_i) begin
            nak_d = 1'b0;
            if (!rx_crc_ok_i) begin
              rewind  = 1'b1;
              state_d = IDLE;
            end else if (dup) begin
              rewind  = 1'b1;
              state_d = RESP;
            end else begin
              flip    = 1'b1;
              state_d = RESP;
              if (pend_vld_q) begin
                wr_en      = 1'b1;
                wr_last    = 1'b1;
                set_commit = 1'b1;
              end
            end
          end else if (rx_tvalid_i) begin
            if (cnt_q == CW'(MAX_PKT)) begin
              rewind  = 1'b1;
              nak_d   = 1'b0;
              state_d = DROP;
            end else begin
              take  = 1'b1;
              wr_en = pend_vld_q;
            end
          end
        end
        DROP: begin
          if (rx_end_i)
            state_d = nak_q ? RESP : IDLE;
        end
        RESP: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && reset_n)
      mem[wr_tmp[ABITS-1:0]] <= {wr_last, pend_q};
    if (rd_req)
      rdata_q <= mem[rd_fetch[ABITS-1:0]];
  end

  // Fetch only while the skid plus the read in flight stays within
  // two entries once this cycle's pop is accounted for.
  assign pop    = m_tvalid_o && m_tready_i;
  assign rd_req = (rd_fetch != wr_cmt) &&
                  ({1'b0, sk_cnt} + {2'b0, rvalid_q} <
                   3'd2 + {2'b0, pop});

  assign m_tvalid_o = sk_cnt != 2'd0;
  assign m_tlast_o  = sk_d[sk_rp][8];
  assign m_tdata_o  = sk_d[sk_rp][7:0];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      nak_q      <= 1'b0;
      commit_q   <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      cnt_q      <= '0;
      wr_tmp     <= '0;
      wr_cmt     <= '0;
      rd_ptr     <= '0;
      rd_fetch   <= '0;
      hs_ack_o   <= 1'b0;
      hs_nak_o   <= 1'b0;
      rvalid_q   <= 1'b0;
      sk_d[0]    <= '0;
      sk_d[1]    <= '0;
      sk_rp      <= 1'b0;
      sk_wp      <= 1'b0;
      sk_cnt     <= '0;
      level_o    <= '0;
`ifdef BULK_OUT_DATA_TOGGLE_EN
      tog_q      <= 1'b0;
      pid_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      nak_q    <= nak_d;
      hs_ack_o <= hs_ack_d;
      hs_nak_o <= hs_nak_d;
      commit_q <= set_commit;
      if (commit_q)
        wr_cmt <= wr_tmp;
      if (rewind)
        wr_tmp <= cmt_eff;
      else if (wr_en)
        wr_tmp <= wr_tmp + ONE;
      if (start) begin
        pend_vld_q <= 1'b0;
        cnt_q      <= '0;
      end else if (take) begin
        pend_vld_q <= 1'b1;
        pend_q     <= rx_tdata_i;
        cnt_q      <= cnt_q + CW'(1);
      end
`ifdef BULK_OUT_DATA_TOGGLE_EN
      if (start)
        pid_q <= rx_data1_i;
      if (flip)
        tog_q <= ~tog_q;
`endif
      rvalid_q <= rd_req;
      if (rd_req)
        rd_fetch <= rd_fetch + ONE;
      if (rvalid_q) begin
        sk_d[sk_wp] <= rdata_q;
        sk_wp       <= ~sk_wp;
      end
      if (pop) begin
        sk_rp  <= ~sk_rp;
        rd_ptr <= rd_ptr + ONE;
      end
      sk_cnt  <= sk_cnt + {1'b0, rvalid_q} - {1'b0, pop};
      level_o <= cmt_eff - (rd_ptr + (ABITS+1)'(pop));
    end
  end

endmodule

// File: tb/tb_bulk_out_pkt_buf.sv
// tb_bulk_out_pkt_buf: directed stimulus with a queue scoreboard for
// output bytes and handshakes, checked by an independent monitor.
module tb_bulk_out_pkt_buf;

  localparam int AB = 10;
  localparam int MP = 512;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx_start_i = 1'b0;
  logic          rx_data1_i = 1'b0;
  logic          rx_tvalid_i = 1'b0;
  logic [7:0]    rx_tdata_i = '0;
  logic          rx_end_i = 1'b0;
  logic          rx_crc_ok_i = 1'b0;
  logic          hs_ack_o, hs_nak_o;
  logic          m_tvalid_o, m_tlast_o;
  logic          m_tready_i = 1'b0;
  logic [7:0]    m_tdata_o;
  logic [AB:0]   level_o;

  bulk_out_pkt_buf #(.ABITS(AB), .MAX_PKT(MP)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_start_i  (rx_start_i),
    .rx_data1_i  (rx_data1_i),
    .rx_tvalid_i (rx_tvalid_i),
    .rx_tdata_i  (rx_tdata_i),
    .rx_end_i    (rx_end_i),
    .rx_crc_ok_i (rx_crc_ok_i),
    .hs_ack_o    (hs_ack_o),
    .hs_nak_o    (hs_nak_o),
    .m_tvalid_o  (m_tvalid_o),
    .m_tready_i  (m_tready_i),
    .m_tlast_o   (m_tlast_o),
    .m_tdata_o   (m_tdata_o),
    .level_o     (level_o)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int last_end = 0;

  logic [8:0] exp_q [$];
  logic       hs_q [$];
  logic [7:0] pkt [$];

  task automatic chk(input string nm, input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, req, $time);
    end
  endtask

  task automatic flag(input string nm, input longint act);
    checks++;
    failures++;
    $display("FAIL %s unexpected actual=%0d t=%0t", nm, act, $time);
  endtask

  logic       stall_q = 1'b0;
  logic [8:0] stall_d = '0;

  always @(negedge clock) begin
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q)
        chk("stable", {m_tvalid_o, m_tlast_o, m_tdata_o},
            {1'b1, stall_d});
      if (m_tvalid_o && m_tready_i) begin
        if (exp_q.size() == 0)
          flag("extra_byte", {m_tlast_o, m_tdata_o});
        else
          chk("byte", {m_tlast_o, m_tdata_o}, exp_q.pop_front());
      end
      if (hs_ack_o || hs_nak_o) begin
        chk("hs_both", hs_ack_o & hs_nak_o, 0);
        chk("hs_time", cyc - last_end, 2);
        if (hs_q.size() == 0)
          flag("extra_hs", {hs_nak_o, hs_ack_o});
        else
          chk("hs_kind", hs_nak_o, hs_q.pop_front());
      end
      stall_q = m_tvalid_o && !m_tready_i;
      stall_d = {m_tlast_o, m_tdata_o};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic fill(input int n, input logic [7:0] seed);
    pkt.delete();
    for (int i = 0; i < n; i++)
      pkt.push_back(8'(i) ^ seed);
  endtask

  task automatic expect_data();
    foreach (pkt[i])
      exp_q.push_back({(i == pkt.size() - 1) ? 1'b1 : 1'b0, pkt[i]});
  endtask

  task automatic send(input logic pid, input logic crc);
    @(posedge clock); #1;
    rx_start_i = 1'b1;
    rx_data1_i = pid;
    @(posedge clock); #1;
    rx_start_i = 1'b0;
    rx_data1_i = 1'b0;
    foreach (pkt[i]) begin
      rx_tvalid_i = 1'b1;
      rx_tdata_i  = pkt[i];
      @(posedge clock); #1;
    end
    rx_tvalid_i = 1'b0;
    rx_tdata_i  = '0;
    rx_end_i    = 1'b1;
    rx_crc_ok_i = crc;
    last_end    = cyc;
    @(posedge clock); #1;
    rx_end_i    = 1'b0;
    rx_crc_ok_i = 1'b0;
  endtask

  // Bounded wait for outstanding handshakes (and bytes when data=1).
  task automatic wait_q(input string nm, input bit data,
                        input int budget);
    int n = 0;
    while ((hs_q.size() != 0 || (data && exp_q.size() != 0)) &&
           n < budget) begin
      @(posedge clock);
      n++;
    end
    tick(3);
    chk(nm, hs_q.size() + (data ? exp_q.size() : 0), 0);
    hs_q.delete();
    if (data)
      exp_q.delete();
  endtask

  initial begin
    int n;
    tick(3);
    chk("rst_tvalid", m_tvalid_o, 0);
    chk("rst_tlast", m_tlast_o, 0);
    chk("rst_tdata", m_tdata_o, 0);
    chk("rst_hs", {hs_ack_o, hs_nak_o}, 0);
    chk("rst_level", level_o, 0);
    reset_n = 1'b1;
    tick(2);

    // Basic 4-byte packet, ready high, commit-to-valid latency.
    m_tready_i = 1'b1;
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
    expect_data();
    hs_q.push_back(1'b0);
    send(1'b0, 1'b1);
    n = 0;
    while (!m_tvalid_o && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("first_valid_lat", cyc - last_end, 4);
    wait_q("t1_drain", 1'b1, 50);
    chk("t1_level", level_o, 0);

    // Bad CRC packet rewound, next good packet alone appears.
    fill(6, 8'h60);
    send(1'b1, 1'b0);
    pkt = '{8'hAA, 8'hBB};
    expect_data();
    hs_q.push_back(1'b0);
    send(1'b1, 1'b1);
    wait_q("t2_drain", 1'b1, 50);
    chk("t2_level", level_o, 0);

    // Data toggle: DATA0, repeated DATA0, DATA1 while stalled.
    m_tready_i = 1'b0;
    pkt = '{8'h01, 8'h02, 8'h03};
    expect_data();
    hs_q.push_back(1'b0);
    send(1'b0, 1'b1);
    wait_q("t3_hs1", 1'b0, 20);
    chk("t3_level1", level_o, 3);
    pkt = '{8'h04, 8'h05, 8'h06};
`ifndef BULK_OUT_DATA_TOGGLE_EN
    expect_data();
`endif
    hs_q.push_back(1'b0);
    send(1'b0, 1'b1);
    wait_q("t3_hs2", 1'b0, 20);
`ifdef BULK_OUT_DATA_TOGGLE_EN
    chk("t3_level_dup", level_o, 3);
`else
    chk("t3_level_dup", level_o, 6);
`endif
    pkt = '{8'h07, 8'h08, 8'h09};
    expect_data();
    hs_q.push_back(1'b0);
    send(1'b1, 1'b1);
    wait_q("t3_hs3", 1'b0, 20);
`ifdef BULK_OUT_DATA_TOGGLE_EN
    chk("t3_level3", level_o, 6);
`else
    chk("t3_level3", level_o, 9);
`endif
    m_tready_i = 1'b1;
    wait_q("t3_drain", 1'b1, 50);
    chk("t3_level0", level_o, 0);

    // Zero-length packet: ACK, nothing written.
    pkt.delete();
    hs_q.push_back(1'b0);
    send(1'b0, 1'b1);
    wait_q("t4_zlp", 1'b1, 20);
    chk("t4_level", level_o, 0);

    // Babble: 513 bytes dropped silently, committed data untouched.
    m_tready_i = 1'b0;
    fill(2, 8'hC0);
    expect_data();
    hs_q.push_back(1'b0);
    send(1'b1, 1'b1);
    wait_q("t5_hs", 1'b0, 20);
    chk("t5_level_a", level_o, 2);
    fill(MP + 1, 8'h3C);
    send(1'b0, 1'b1);
    tick(6);
    chk("t5_level_b", level_o, 2);
    m_tready_i = 1'b1;
    wait_q("t5_drain", 1'b1, 50);
    m_tready_i = 1'b0;

    // Space check: exactly enough room is accepted, then NAK.
    fill(MP, 8'h00);
    expect_data();
    hs_q.push_back(1'b0);
    send(1'b0, 1'b1);
    wait_q("t6_hs1", 1'b0, 20);
    chk("t6_level1", level_o, 512);
    fill(MP, 8'h5A);
    expect_data();
    hs_q.push_back(1'b0);
    send(1'b1, 1'b1);
    wait_q("t6_hs2", 1'b0, 20);
    chk("t6_level2", level_o, 1024);
    fill(MP, 8'hF0);
    hs_q.push_back(1'b1);
    send(1'b0, 1'b1);
    wait_q("t6_nak", 1'b0, 20);
    chk("t6_level3", level_o, 1024);
    m_tready_i = 1'b1;
    wait_q("t6_drain", 1'b1, 1200);
    chk("t6_level0", level_o, 0);

    // Reset mid-packet discards committed and partial data.
    m_tready_i = 1'b0;
    fill(2, 8'h70);
    expect_data();
    hs_q.push_back(1'b0);
    send(1'b0, 1'b1);
    wait_q("t7_hs", 1'b0, 20);
    chk("t7_level_pre", level_o, 2);
    fill(100, 8'h90);
    @(posedge clock); #1;
    rx_start_i = 1'b1;
    rx_data1_i = 1'b1;
    @(posedge clock); #1;
    rx_start_i = 1'b0;
    rx_data1_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      rx_tvalid_i = 1'b1;
      rx_tdata_i  = pkt[i];
      @(posedge clock); #1;
    end
    reset_n     = 1'b0;
    rx_tvalid_i = 1'b0;
    rx_tdata_i  = '0;
    exp_q.delete();
    tick(1);
    chk("t7_tvalid", m_tvalid_o, 0);
    chk("t7_tlast", m_tlast_o, 0);
    chk("t7_tdata", m_tdata_o, 0);
    chk("t7_hs", {hs_ack_o, hs_nak_o}, 0);
    chk("t7_level", level_o, 0);
    reset_n = 1'b1;
    tick(4);
    chk("t7_level_post", level_o, 0);

    // Toggle back at DATA0 after reset: DATA0 is accepted.
    m_tready_i = 1'b1;
    pkt = '{8'h5A};
    expect_data();
    hs_q.push_back(1'b0);
    send(1'b0, 1'b1);
    wait_q("t8_drain", 1'b1, 50);
    tick(10);
    chk("t8_level", level_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
